// File: rtl/axi4_slave_pkg.sv
// rtl/axi4_slave_pkg.sv - shared types and constants for the 32x16 AXI4-style slave
package axi4_slave_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // WR_IDLE/RD_IDLE are the reset states; the first edge after reset leaves them.
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axi4_slave_regfile.sv
// rtl/axi4_slave_regfile.sv - 2**ADDR_W x DATA_W storage, one write port, one combinational read port
module axi4_slave_regfile
  import axi4_slave_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Whole array clears on reset; otherwise one word written per edge when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read FSM registers this value, so a same-edge write yields old data.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_slave_mem32.sv
// rtl/axi4_slave_mem32.sv - single-beat AXI4-style slave with independent write and read FSMs
module axi4_slave_mem32
  import axi4_slave_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] A_W_ADDR,
  input  logic              A_W_VALID,
  output logic              A_W_READY,
  input  logic [DATA_W-1:0] W_DATA,
  input  logic              W_VALID,
  output logic              W_READY,
  output logic              B_VALID,
  output logic [1:0]        B_RESP,
  input  logic              B_READY,
  input  logic [ADDR_W-1:0] A_R_ADDR,
  input  logic              A_R_VALID,
  output logic              A_R_READY,
  output logic [DATA_W-1:0] R_DATA,
  output logic              R_VALID,
  output logic              RRSEP,
  input  logic              R_READY
);

  wr_state_t         wr_state;
  rd_state_t         rd_state;
  logic [ADDR_W-1:0] wr_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign mem_we = (wr_state == WR_DATA) && W_VALID && W_READY;

  axi4_slave_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_regfile (
    .clk   (CLK),
    .rst_n (RESET),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (W_DATA),
    .raddr (A_R_ADDR),
    .rdata (mem_rdata)
  );

  // Write channel: address, then data, then response; one transaction at a time.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_state  <= WR_IDLE;
      wr_addr   <= '0;
      A_W_READY <= 1'b0;
      W_READY   <= 1'b0;
      B_VALID   <= 1'b0;
      B_RESP    <= RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          A_W_READY <= 1'b1;
          wr_state  <= WR_ADDR;
        end
        WR_ADDR: begin
          if (A_W_VALID && A_W_READY) begin
            wr_addr   <= A_W_ADDR;
            A_W_READY <= 1'b0;
            W_READY   <= 1'b1;
            wr_state  <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (W_VALID && W_READY) begin
            W_READY  <= 1'b0;
            B_VALID  <= 1'b1;
            B_RESP   <= RESP_OKAY;
            wr_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (B_VALID && B_READY) begin
            B_VALID   <= 1'b0;
            A_W_READY <= 1'b1;
            wr_state  <= WR_ADDR;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read channel: capture the word on the address handshake, hold it until accepted.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_state  <= RD_IDLE;
      A_R_READY <= 1'b0;
      R_VALID   <= 1'b0;
      RRSEP     <= 1'b0;
      R_DATA    <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          A_R_READY <= 1'b1;
          rd_state  <= RD_ADDR;
        end
        RD_ADDR: begin
          if (A_R_VALID && A_R_READY) begin
            R_DATA    <= mem_rdata;
            RRSEP     <= 1'b0;
            A_R_READY <= 1'b0;
            R_VALID   <= 1'b1;
            rd_state  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (R_VALID && R_READY) begin
            R_VALID   <= 1'b0;
            A_R_READY <= 1'b1;
            rd_state  <= RD_ADDR;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem32.sv
// tb/tb_axi4_slave_mem32.sv - directed and randomized bench for axi4_slave_mem32
module tb_axi4_slave_mem32;

  logic        CLK;
  logic        RESET;
  logic [4:0]  A_W_ADDR;
  logic        A_W_VALID;
  logic        A_W_READY;
  logic [15:0] W_DATA;
  logic        W_VALID;
  logic        W_READY;
  logic        B_VALID;
  logic [1:0]  B_RESP;
  logic        B_READY;
  logic [4:0]  A_R_ADDR;
  logic        A_R_VALID;
  logic        A_R_READY;
  logic [15:0] R_DATA;
  logic        R_VALID;
  logic        RRSEP;
  logic        R_READY;

  int checks;
  int failures;
  int model_mem [32];

  axi4_slave_mem32 dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .A_W_ADDR  (A_W_ADDR),
    .A_W_VALID (A_W_VALID),
    .A_W_READY (A_W_READY),
    .W_DATA    (W_DATA),
    .W_VALID   (W_VALID),
    .W_READY   (W_READY),
    .B_VALID   (B_VALID),
    .B_RESP    (B_RESP),
    .B_READY   (B_READY),
    .A_R_ADDR  (A_R_ADDR),
    .A_R_VALID (A_R_VALID),
    .A_R_READY (A_R_READY),
    .R_DATA    (R_DATA),
    .R_VALID   (R_VALID),
    .RRSEP     (RRSEP),
    .R_READY   (R_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_aw_ready();
    int n = 0;
    while (!A_W_READY && n < 50) begin @(negedge CLK); n++; end
    check("aw_ready_timeout", 32'(n < 50), 1);
  endtask

  task automatic do_write(input int addr, input int data, input bit hold_b);
    int n = 0;
    @(negedge CLK);
    A_W_ADDR = 5'(addr); A_W_VALID = 1'b1;
    W_DATA = 16'(data); W_VALID = 1'b1;
    B_READY = !hold_b;
    wait_aw_ready();
    @(negedge CLK);
    A_W_VALID = 1'b0;
    while (!W_READY && n < 50) begin @(negedge CLK); n++; end
    check("w_ready_timeout", 32'(n < 50), 1);
    @(negedge CLK);
    W_VALID = 1'b0;
    model_mem[addr] = data & 16'hFFFF;
    check("b_valid_rise", B_VALID, 1);
    check("b_resp", B_RESP, 0);
    check("aw_ready_busy", A_W_READY, 0);
    if (hold_b) begin
      repeat (5) begin
        @(negedge CLK);
        check("b_valid_held", B_VALID, 1);
        check("aw_ready_held", A_W_READY, 0);
      end
      B_READY = 1'b1;
    end
    @(negedge CLK);
    check("b_valid_fall", B_VALID, 0);
    check("aw_ready_back", A_W_READY, 1);
  endtask

  task automatic do_read(input int addr, output logic [15:0] data);
    int n = 0;
    @(negedge CLK);
    A_R_ADDR = 5'(addr); A_R_VALID = 1'b1; R_READY = 1'b1;
    while (!A_R_READY && n < 50) begin @(negedge CLK); n++; end
    check("ar_ready_timeout", 32'(n < 50), 1);
    @(negedge CLK);
    A_R_VALID = 1'b0;
    check("r_valid_rise", R_VALID, 1);
    check("rrsep", RRSEP, 0);
    data = R_DATA;
    @(negedge CLK);
    check("r_valid_one_beat", R_VALID, 0);
    check("r_data_retained", R_DATA, data);
    check("ar_ready_back", A_R_READY, 1);
  endtask

  initial begin
    logic [15:0] rd;
    int a;
    int d;
    int old5;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) model_mem[i] = 0;
    RESET = 1'b0;
    A_W_ADDR = '0; A_W_VALID = 1'b0; W_DATA = '0; W_VALID = 1'b0; B_READY = 1'b1;
    A_R_ADDR = '0; A_R_VALID = 1'b0; R_READY = 1'b1;

    // reset values
    @(negedge CLK);
    check("rst_aw_ready", A_W_READY, 0);
    check("rst_ar_ready", A_R_READY, 0);
    check("rst_b_valid", B_VALID, 0);
    check("rst_r_valid", R_VALID, 0);
    check("rst_r_data", R_DATA, 0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_aw_ready", A_W_READY, 1);
    check("idle_ar_ready", A_R_READY, 1);
    check("idle_w_ready", W_READY, 0);
    check("idle_b_valid", B_VALID, 0);
    check("idle_r_valid", R_VALID, 0);
    check("idle_b_resp", B_RESP, 0);
    do_read(7, rd);
    check("rd7_after_reset", rd, 0);

    // single write/read at top address
    do_write(31, 182, 1'b0);
    do_read(31, rd);
    check("rd31", rd, 182);

    // fill all addresses, read back descending
    for (int i = 0; i < 32; i++) do_write(i, 1000 + i, 1'b0);
    for (int i = 31; i >= 0; i--) begin
      do_read(i, rd);
      check("fill_readback", rd, 32'(model_mem[i]));
      check("fill_expected", rd, 32'(1000 + i));
    end

    // response back-pressure
    do_write(12, 16'hBEEF, 1'b1);

    // W before AW is ignored
    @(negedge CLK);
    W_DATA = 16'h55AA; W_VALID = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("w_ready_before_aw", W_READY, 0);
    end
    W_VALID = 1'b0;
    do_read(3, rd);
    check("mem3_unchanged", rd, 32'(model_mem[3]));
    do_write(3, 16'h55AA, 1'b0);
    do_read(3, rd);
    check("mem3_written", rd, 32'h55AA);

    // same-edge W and AR handshake to one address returns old data
    old5 = model_mem[5];
    @(negedge CLK);
    A_W_ADDR = 5'd5; A_W_VALID = 1'b1; B_READY = 1'b1;
    wait_aw_ready();
    @(negedge CLK);
    A_W_VALID = 1'b0;
    check("coll_w_ready", W_READY, 1);
    check("coll_ar_ready", A_R_READY, 1);
    W_DATA = 16'h0F0F; W_VALID = 1'b1;
    A_R_ADDR = 5'd5; A_R_VALID = 1'b1;
    @(negedge CLK);
    W_VALID = 1'b0; A_R_VALID = 1'b0;
    model_mem[5] = 16'h0F0F;
    check("coll_r_valid", R_VALID, 1);
    check("coll_old_data", R_DATA, 32'(old5));
    check("coll_b_valid", B_VALID, 1);
    @(negedge CLK);
    check("coll_done_r", R_VALID, 0);
    check("coll_done_b", B_VALID, 0);
    do_read(5, rd);
    check("coll_new_data", rd, 32'h0F0F);

    // randomized traffic against the model
    for (int k = 0; k < 30; k++) begin
      a = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        d = int'($urandom_range(0, 65535));
        do_write(a, d, 1'b0);
      end else begin
        do_read(a, rd);
        check("rand_read", rd, 32'(model_mem[a]));
      end
    end

    // reset in the middle of a write
    do_write(9, 16'h1234, 1'b0);
    do_read(9, rd);
    check("mem9_pre_reset", rd, 32'h1234);
    @(negedge CLK);
    A_W_ADDR = 5'd9; A_W_VALID = 1'b1;
    wait_aw_ready();
    @(negedge CLK);
    A_W_VALID = 1'b0;
    check("mid_w_ready", W_READY, 1);
    RESET = 1'b0;
    for (int i = 0; i < 32; i++) model_mem[i] = 0;
    #1;
    check("arst_aw_ready", A_W_READY, 0);
    check("arst_w_ready", W_READY, 0);
    check("arst_b_valid", B_VALID, 0);
    check("arst_b_resp", B_RESP, 0);
    check("arst_ar_ready", A_R_READY, 0);
    check("arst_r_valid", R_VALID, 0);
    check("arst_rrsep", RRSEP, 0);
    check("arst_r_data", R_DATA, 0);
    @(negedge CLK);
    RESET = 1'b1;
    do_read(9, rd);
    check("mem9_after_reset", rd, 32'(model_mem[9]));
    check("mem9_zero", rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem32.md
Name: axi4_slave_mem32

Overview:
- Simple AXI4-style slave (single-beat, lite-like) fronting a 32 x 16-bit register memory.
- Independent write channel (address, data, response) and read channel (address, data) are each driven by their own FSM.
- Sits behind a master/bus driver; every access is a single transfer, with no bursts, IDs or strobes.

Parameters:
- ADDR_W, 5, address width; memory depth is 2**ADDR_W = 32 words.
- DATA_W, 16, data word width.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RESET  in  1  reset, asynchronous and active-low.
- A_W_ADDR  in  ADDR_W  write address.
- A_W_VALID  in  1  write address valid.
- A_W_READY  out  1  slave can accept the write address.
- W_DATA  in  DATA_W  write data.
- W_VALID  in  1  write data valid.
- W_READY  out  1  slave can accept write data.
- B_VALID  out  1  write response valid.
- B_RESP  out  2  write response code.
- B_READY  in  1  master accepts the write response.
- A_R_ADDR  in  ADDR_W  read address.
- A_R_VALID  in  1  read address valid.
- A_R_READY  out  1  slave can accept the read address.
- R_DATA  out  DATA_W  read data.
- R_VALID  out  1  read data valid.
- RRSEP  out  1  read response status (0 = OKAY).
- R_READY  in  1  master accepts the read data.

Behaviour:
- Handshake: a transfer occurs on a rising edge where VALID and READY are both 1. All outputs are registered.
- Reset (RESET=0, async):
  - both FSMs go to IDLE; all memory words clear to 0.
  - A_W_READY, W_READY, B_VALID, A_R_READY, R_VALID, RRSEP = 0; B_RESP = 2'b00; R_DATA = 0.
  - Reset asserted mid-transaction aborts it, and no memory write occurs unless the W handshake already completed.
- Write FSM states are WR_ADDR, WR_DATA and WR_RESP:
  - WR_ADDR: A_W_READY=1; the first edge after reset release enters this state.
  - On AW handshake: latch A_W_ADDR, A_W_READY->0, W_READY->1, go to WR_DATA.
  - WR_DATA: on W handshake write mem[latched addr] <= W_DATA, W_READY->0, B_VALID->1, B_RESP=2'b00, go to WR_RESP.
  - WR_RESP: on B handshake B_VALID->0, A_W_READY->1, return to WR_ADDR.
  - One transaction is outstanding at a time. W_VALID before the AW handshake is ignored (W_READY=0). B_VALID is held until B_READY.
- Read FSM states are RD_ADDR and RD_DATA:
  - RD_ADDR: A_R_READY=1.
  - On AR handshake: R_DATA <= mem[A_R_ADDR], RRSEP=0, A_R_READY->0, R_VALID->1, go to RD_DATA.
  - RD_DATA: R_DATA is held stable; on R handshake R_VALID->0, A_R_READY->1, return to RD_ADDR.
- Each ready/valid output pulses for at least 1 cycle and falls on the cycle after its handshake. Masters may key off the falling edge.
- Minimum transaction time: write is 3 handshake edges; read is 2.
- All 32 addresses are valid; no SLVERR/DECERR is ever generated. Addresses use ADDR_W bits, so there is no out-of-range case.
- Simultaneous AR handshake and W handshake to the same address on the same edge: the read returns the OLD data.
- Read and write channels run concurrently and independently.
- R_DATA retains its last value after R_VALID drops.

Decomposition:
- Package axi4_slave_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - write FSM state enum (WR_ADDR, WR_DATA, WR_RESP);
  - read FSM state enum (RD_ADDR, RD_DATA);
  - default ADDR_W/DATA_W.
- One sub-module, axi4_slave_regfile:
  - 32 x DATA_W storage with async active-low clear;
  - one synchronous write port;
  - one read port registered by the read FSM.

Test Plan:
- Reset, then idle for 2 cycles -> A_W_READY=1, A_R_READY=1, B_VALID=0, R_VALID=0, B_RESP=0. Read address 7 -> R_DATA=0, RRSEP=0.
- Write addr 31, data 182 (VALIDs asserted, each dropped after its READY falls; B_READY=1) -> B_VALID pulses with B_RESP=00. Read addr 31 -> R_VALID=1, R_DATA=182.
- Write all 32 addresses with data = 1000+addr, then read them in descending order 31..0 -> each R_DATA = 1000+addr, and each readback takes exactly one R handshake.
- Hold B_READY=0 for 5 cycles after a write -> B_VALID stays 1 and A_W_READY stays 0. Raise B_READY -> B_VALID falls next edge and A_W_READY returns to 1.
- Assert W_VALID with data 0x55AA before any AW handshake -> W_READY stays 0 and memory is unchanged. The following AW to addr 3 then W handshake -> mem[3]=0x55AA.
- Assert RESET=0 while in WR_DATA (address 9 already latched) -> all outputs return to reset values asynchronously and mem[9]=0. After release, a read of address 9 returns 0.
